frame5_collect: RTL and testbench

FRAME5_COLLECT -- requirements
Module: frame5_collect

---
 rtl/sort5_pkg.sv | 9 +
 rtl/frame5_collect.sv | 112 +++++++++++
 tb/tb_frame5_collect.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/sort5_pkg.sv
// Shared definitions for the 5-word frame collector and the 5-input sorter stage.
package sort5_pkg;

  localparam int FRAME_WORDS       = 5;
  localparam int DEFAULT_INT_WIDTH = 8;

  typedef logic [0:FRAME_WORDS-1][DEFAULT_INT_WIDTH-1:0] frame_t;

endpackage

// File: rtl/frame5_collect.sv
// Collects serial integer words into 5-word frames with padding for short frames,
// a one-deep pending slot, and a registered output that feeds the sorter directly.
module frame5_collect
  import sort5_pkg::*;
#(
  parameter int                   INT_WIDTH = DEFAULT_INT_WIDTH,
  parameter logic [INT_WIDTH-1:0] PAD_VALUE = {INT_WIDTH{1'b1}}
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [INT_WIDTH-1:0]                      in_data,
  input  logic                                      in_last,
  output logic                                      frame_valid,
  input  logic                                      frame_ready,
  output logic [0:FRAME_WORDS-1][INT_WIDTH-1:0]     frame_data,
  output logic [2:0]                                frame_len
);

  typedef logic [0:FRAME_WORDS-1][INT_WIDTH-1:0] word_frame_t;

  logic [2:0]  cnt_q, cnt_d;
  word_frame_t buf_q, buf_d;
  logic        pending_q, pending_d;
  logic [2:0]  pend_len_q, pend_len_d;
  logic        out_valid_q, out_valid_d;
  word_frame_t out_data_q, out_data_d;
  logic [2:0]  out_len_q, out_len_d;

  word_frame_t complete_frame;
  logic        accept;
  logic        complete;
  logic        out_free;

  assign in_ready    = !rst && !pending_q;
  assign accept      = in_valid && in_ready;
  assign complete    = accept && (cnt_q == 3'd4 || in_last);
  assign out_free    = !out_valid_q || frame_ready;

  assign frame_valid = out_valid_q;
  assign frame_data  = out_data_q;
  assign frame_len   = out_len_q;

  // Frame as it would look if the current word closed it: earlier slots from
  // the fill buffer, the current word at cnt, padding above.
  always_comb begin
    complete_frame = buf_q;
    for (int i = 0; i < FRAME_WORDS; i++) begin
      if (3'(i) == cnt_q) begin
        complete_frame[i] = in_data;
      end else if (3'(i) > cnt_q) begin
        complete_frame[i] = PAD_VALUE;
      end
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    pending_d   = pending_q;
    pend_len_d  = pend_len_q;
    out_valid_d = out_valid_q && !frame_ready;
    out_data_d  = out_data_q;
    out_len_d   = out_len_q;

    if (pending_q) begin
      // in_ready is low while pending, so no word can arrive on this edge
      if (out_free) begin
        out_valid_d = 1'b1;
        out_data_d  = buf_q;
        out_len_d   = pend_len_q;
        pending_d   = 1'b0;
      end
    end else if (complete) begin
      cnt_d = 3'd0;
      if (out_free) begin
        out_valid_d = 1'b1;
        out_data_d  = complete_frame;
        out_len_d   = cnt_q + 3'd1;
      end else begin
        buf_d      = complete_frame;
        pending_d  = 1'b1;
        pend_len_d = cnt_q + 3'd1;
      end
    end else if (accept) begin
      buf_d[cnt_q] = in_data;
      cnt_d        = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      buf_q       <= '0;
      pending_q   <= 1'b0;
      pend_len_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_len_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      pending_q   <= pending_d;
      pend_len_q  <= pend_len_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_len_q   <= out_len_d;
    end
  end

endmodule

// File: tb/tb_frame5_collect.sv
// Scoreboard bench for frame5_collect: directed word streams push expected frames,
// a negedge monitor pops and compares every transferred frame.
module tb_frame5_collect;
  import sort5_pkg::*;

  typedef struct {
    frame_t     data;
    logic [2:0] len;
  } exp_frame_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       frame_valid;
  logic       frame_ready;
  frame_t     frame_data;
  logic [2:0] frame_len;

  exp_frame_t expQ[$];
  int         checks;
  int         passes;
  int         cyc;
  int         lastPop;
  logic       gapCheck;
  logic       gapArmed;
  logic       holdValid;
  frame_t     holdData;
  logic [2:0] holdLen;

  frame5_collect #(.INT_WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_data(frame_data),
    .frame_len(frame_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic frame_t mk(input logic [7:0] a, b, c, d, e);
    frame_t f;
    f[0] = a; f[1] = b; f[2] = c; f[3] = d; f[4] = e;
    return f;
  endfunction

  task automatic pushExp(input frame_t d, input logic [2:0] l);
    exp_frame_t e;
    e.data = d;
    e.len  = l;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual === required) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
  endtask

  // Drives one word from just after a rising edge and returns just after the edge that accepted it.
  task automatic applyStimulus(input logic [7:0] d, input logic l, output int stalls);
    logic taken;
    stalls   = 0;
    taken    = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int n = 0; n < 50 && !taken; n++) begin
      @(negedge clk);
      taken = in_ready;
      if (!taken) stalls++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!taken) begin
      checks++;
      $display("[TB] FAIL word_accept_timeout: got no accept, expected accept of %0d", d);
    end
  endtask

  // Monitor: pops one expected frame per transfer, and checks hold stability while stalled.
  always @(negedge clk) begin
    if (frame_valid === 1'b1 && frame_ready === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_frame: got frame len %0d, expected none", frame_len);
      end else begin
        exp_frame_t e;
        e = expQ.pop_front();
        checkOutput("frame_data", 64'(frame_data), 64'(e.data));
        checkOutput("frame_len", 64'(frame_len), 64'(e.len));
        if (gapCheck) begin
          if (gapArmed) checkOutput("frame_gap", 64'(cyc - lastPop), 64'd5);
          gapArmed = 1'b1;
          lastPop  = cyc;
        end
      end
      holdValid = 1'b0;
    end else if (frame_valid === 1'b1) begin
      if (holdValid) begin
        checkOutput("hold_data", 64'(frame_data), 64'(holdData));
        checkOutput("hold_len", 64'(frame_len), 64'(holdLen));
      end
      holdValid = 1'b1;
      holdData  = frame_data;
      holdLen   = frame_len;
    end else begin
      holdValid = 1'b0;
    end
  end

  initial begin
    int st;
    int totalStalls;
    checks = 0; passes = 0; cyc = 0; lastPop = 0;
    gapCheck = 1'b0; gapArmed = 1'b0; holdValid = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; frame_ready = 1'b0;

    @(negedge clk);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_valid", 64'(frame_valid), 64'd0);
    checkOutput("reset_data", 64'(frame_data), 64'd0);
    checkOutput("reset_len", 64'(frame_len), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Full frame, downstream ready, latency one cycle after the fifth word
    frame_ready = 1'b1;
    pushExp(mk(5, 3, 9, 1, 7), 3'd5);
    applyStimulus(8'd5, 1'b0, st);
    applyStimulus(8'd3, 1'b0, st);
    applyStimulus(8'd9, 1'b0, st);
    applyStimulus(8'd1, 1'b0, st);
    applyStimulus(8'd7, 1'b0, st);
    @(negedge clk);
    checkOutput("latency_valid", 64'(frame_valid), 64'd1);
    @(posedge clk); #1;

    // Short frames padded with all ones
    pushExp(mk(4, 2, 8'hFF, 8'hFF, 8'hFF), 3'd2);
    applyStimulus(8'd4, 1'b0, st);
    applyStimulus(8'd2, 1'b1, st);
    pushExp(mk(8, 8'hFF, 8'hFF, 8'hFF, 8'hFF), 3'd1);
    applyStimulus(8'd8, 1'b1, st);
    pushExp(mk(6, 5, 4, 3, 2), 3'd5);
    applyStimulus(8'd6, 1'b0, st);
    applyStimulus(8'd5, 1'b0, st);
    applyStimulus(8'd4, 1'b0, st);
    applyStimulus(8'd3, 1'b0, st);
    applyStimulus(8'd2, 1'b1, st);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: first frame held, second goes pending
    frame_ready = 1'b0;
    pushExp(mk(1, 2, 3, 4, 5), 3'd5);
    pushExp(mk(6, 7, 8, 9, 10), 3'd5);
    for (int w = 1; w <= 10; w++) applyStimulus(8'(w), 1'b0, st);
    @(negedge clk);
    checkOutput("pend_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_data  = 8'd99;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    frame_ready = 1'b1;
    @(negedge clk);
    checkOutput("pend_in_ready_still", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("pend_in_ready_back", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Sustained stream of 20 words, frames five cycles apart
    gapCheck = 1'b1;
    totalStalls = 0;
    for (int f = 0; f < 4; f++)
      pushExp(mk(8'(11 + 5*f), 8'(12 + 5*f), 8'(13 + 5*f), 8'(14 + 5*f), 8'(15 + 5*f)), 3'd5);
    for (int w = 11; w <= 30; w++) begin
      applyStimulus(8'(w), 1'b0, st);
      totalStalls += st;
    end
    checkOutput("stream_stalls", 64'(totalStalls), 64'd0);
    repeat (2) @(posedge clk);
    #1 gapCheck = 1'b0;

    // Reset mid-frame discards partial words
    applyStimulus(8'd40, 1'b0, st);
    applyStimulus(8'd41, 1'b0, st);
    applyStimulus(8'd42, 1'b0, st);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_valid", 64'(frame_valid), 64'd0);
    checkOutput("midrst_len", 64'(frame_len), 64'd0);
    @(posedge clk); #1;
    pushExp(mk(21, 22, 23, 24, 25), 3'd5);
    for (int w = 21; w <= 25; w++) applyStimulus(8'(w), 1'b0, st);

    for (int n = 0; n < 20 && expQ.size() != 0; n++) @(posedge clk);
    @(negedge clk);
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
